spi_target: RTL and testbench

- SPI target (slave) peripheral: the responding end of the SPI interface that the IO multiplexer drives as initiator.
- An external SPI master drives sck, cs and mosi onto GPIO pads; this block returns miso plus a pad output-enable.
- Fixed SPI mode 0 (CPOL=0, CPHA=0). All pad inputs are oversampled in the clk domain.
- Offers a one-word TX buffer and a one-word RX holding register to a register/Wishbone front end.

---
 rtl/spi_target.sv | 179 +++++++++++++++++
 tb/tb_spi_target.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_target.sv
// SPI mode-0 target with pad oversampling, a one-word TX buffer and a one-word
// RX holding register for a register-bus front end.
module spi_target #(
  parameter int               WIDTH       = 8,
  parameter int               SYNC_STAGES = 2,
  parameter logic [WIDTH-1:0] TX_DEFAULT  = 8'hFF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             spi_sck,
  input  logic             spi_cs,
  input  logic             spi_mosi,
  output logic             spi_miso,
  output logic             spi_miso_oeb,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_write,
  output logic             tx_full,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  input  logic             rx_ack,
  output logic             rx_overrun,
  output logic             tx_underrun,
  output logic             frame_abort,
  output logic             busy
);

  // state  | meaning
  // IDLE   | cs high, pad not driven, waiting for a synchronized cs fall
  // ACTIVE | frame in progress, shifting on synchronized sck edges
  typedef enum logic {IDLE, ACTIVE} state_t;

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  logic [SYNC_STAGES-1:0] sck_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   sck_dly;
  logic                   cs_dly;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sck_sync  <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      sck_dly   <= 1'b0;
      cs_dly    <= 1'b1;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi_sck};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      sck_dly   <= sck_sync[SYNC_STAGES-1];
      cs_dly    <= cs_sync[SYNC_STAGES-1];
    end
  end

  logic sck_s, cs_s, mosi_s;
  logic sck_rise, sck_fall, cs_fall, cs_rise;

  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign cs_s     = cs_sync[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_dly;
  assign sck_fall = ~sck_s & sck_dly;
  assign cs_fall  = ~cs_s & cs_dly;
  assign cs_rise  = cs_s & ~cs_dly;

  state_t           state;
  logic [CW-1:0]    bit_cnt;
  logic [WIDTH-1:0] tx_shift;
  logic [WIDTH-1:0] rx_shift;
  logic [WIDTH-1:0] tx_buf;
  logic             reload;
  logic             started;
  logic             word_done;
  logic [WIDTH-1:0] load_word;

  // Word that a load would take right now: buffered data, or the idle pattern.
  assign load_word = tx_full ? tx_buf : TX_DEFAULT;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      bit_cnt      <= '0;
      tx_shift     <= '0;
      rx_shift     <= '0;
      tx_buf       <= '0;
      tx_full      <= 1'b0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      spi_miso     <= 1'b0;
      spi_miso_oeb <= 1'b1;
      rx_overrun   <= 1'b0;
      tx_underrun  <= 1'b0;
      frame_abort  <= 1'b0;
      busy         <= 1'b0;
      reload       <= 1'b0;
      started      <= 1'b0;
      word_done    <= 1'b0;
    end else begin
      rx_overrun  <= 1'b0;
      tx_underrun <= 1'b0;
      frame_abort <= 1'b0;
      word_done   <= 1'b0;

      // Completion beats a same-cycle ack, and an ack suppresses the overrun.
      if (word_done) begin
        rx_data  <= rx_shift;
        rx_valid <= 1'b1;
        if (rx_valid && !rx_ack) rx_overrun <= 1'b1;
      end else if (rx_ack) begin
        rx_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          spi_miso_oeb <= 1'b1;
          busy         <= 1'b0;
          if (cs_fall) begin
            state        <= ACTIVE;
            busy         <= 1'b1;
            spi_miso_oeb <= 1'b0;
            bit_cnt      <= '0;
            reload       <= 1'b0;
            started      <= 1'b0;
            tx_shift     <= load_word;
            spi_miso     <= load_word[WIDTH-1];
            if (tx_full) tx_full <= 1'b0;
            else         tx_underrun <= 1'b1;
          end
        end

        ACTIVE: begin
          if (cs_rise) begin
            state        <= IDLE;
            busy         <= 1'b0;
            spi_miso_oeb <= 1'b1;
            bit_cnt      <= '0;
            reload       <= 1'b0;
            if (bit_cnt != '0) frame_abort <= 1'b1;
          end else begin
            spi_miso_oeb <= 1'b0;
            if (sck_rise) begin
              rx_shift <= {rx_shift[WIDTH-2:0], mosi_s};
              started  <= 1'b1;
              if (bit_cnt == LAST_BIT) begin
                bit_cnt   <= '0;
                reload    <= 1'b1;
                word_done <= 1'b1;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end else if (sck_fall && started) begin
              if (reload) begin
                reload   <= 1'b0;
                tx_shift <= load_word;
                spi_miso <= load_word[WIDTH-1];
                if (tx_full) tx_full <= 1'b0;
                else         tx_underrun <= 1'b1;
              end else begin
                tx_shift <= tx_shift << 1;
                spi_miso <= tx_shift[WIDTH-2];
              end
            end
          end
        end

        default: state <= IDLE;
      endcase

      // A write lands after any same-cycle load, so the load sees the old buffer.
      if (tx_write) begin
        tx_buf  <= tx_data;
        tx_full <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_spi_target.sv
// Directed bench for spi_target: a mode-0 master at clk/8 exercising byte
// exchange, back-to-back words, under/overrun, abort, reset and ack collision.
module tb_spi_target;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       spi_sck = 1'b0;
  logic       spi_cs = 1'b1;
  logic       spi_mosi = 1'b0;
  logic       spi_miso;
  logic       spi_miso_oeb;
  logic [7:0] tx_data = 8'h00;
  logic       tx_write = 1'b0;
  logic       tx_full;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ack = 1'b0;
  logic       rx_overrun;
  logic       tx_underrun;
  logic       frame_abort;
  logic       busy;

  spi_target #(.WIDTH(8), .SYNC_STAGES(2), .TX_DEFAULT(8'hFF)) dut (
    .clk          (clk),
    .rst          (rst),
    .spi_sck      (spi_sck),
    .spi_cs       (spi_cs),
    .spi_mosi     (spi_mosi),
    .spi_miso     (spi_miso),
    .spi_miso_oeb (spi_miso_oeb),
    .tx_data      (tx_data),
    .tx_write     (tx_write),
    .tx_full      (tx_full),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ack       (rx_ack),
    .rx_overrun   (rx_overrun),
    .tx_underrun  (tx_underrun),
    .frame_abort  (frame_abort),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  int n_under = 0;
  int n_over = 0;
  int n_abort = 0;
  int u0, o0, a0, k;
  logic [7:0] m1, m2;

  always @(negedge clk) begin
    if (tx_underrun) n_under++;
    if (rx_overrun)  n_over++;
    if (frame_abort) n_abort++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic write_tx(input logic [7:0] d);
    tx_data  = d;
    tx_write = 1'b1;
    tick(1);
    tx_write = 1'b0;
  endtask

  task automatic ack_rx();
    rx_ack = 1'b1;
    tick(1);
    rx_ack = 1'b0;
  endtask

  // Shift nbits MSB-first; on the final bit the sck fall can coincide with cs
  // rising, and rx_ack can be timed onto the word-completion cycle.
  task automatic xfer(input logic [7:0] mo, input int nbits, input bit last,
                      input bit ack_done, output logic [7:0] mi);
    mi = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = mo[7-i];
      tick(4);
      mi = {mi[6:0], spi_miso};
      spi_sck = 1'b1;
      if (ack_done && i == nbits - 1) begin
        tick(3);
        rx_ack = 1'b1;
        tick(1);
        rx_ack = 1'b0;
      end else begin
        tick(4);
      end
      spi_sck = 1'b0;
      if (last && i == nbits - 1) spi_cs = 1'b1;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1);
  end

  initial begin
    tick(3);
    check("rst_miso", 16'(spi_miso), 16'h0);
    check("rst_oeb", 16'(spi_miso_oeb), 16'h1);
    check("rst_tx_full", 16'(tx_full), 16'h0);
    check("rst_rx_data", 16'(rx_data), 16'h00);
    check("rst_rx_valid", 16'(rx_valid), 16'h0);
    check("rst_busy", 16'(busy), 16'h0);
    rst = 1'b1;
    tick(2);

    // Single byte exchange
    u0 = n_under; o0 = n_over; a0 = n_abort;
    write_tx(8'h3C);
    check("t1_tx_full_set", 16'(tx_full), 16'h1);
    spi_cs = 1'b0;
    tick(4);
    check("t1_oeb_active", 16'(spi_miso_oeb), 16'h0);
    check("t1_busy", 16'(busy), 16'h1);
    xfer(8'hA5, 8, 1'b1, 1'b0, m1);
    tick(6);
    check("t1_miso_word", 16'(m1), 16'h3C);
    check("t1_rx_data", 16'(rx_data), 16'hA5);
    check("t1_rx_valid", 16'(rx_valid), 16'h1);
    check("t1_tx_full", 16'(tx_full), 16'h0);
    check("t1_oeb_idle", 16'(spi_miso_oeb), 16'h1);
    check("t1_pulses", 16'((n_under - u0) + (n_over - o0) + (n_abort - a0)), 16'h0);

    // Back-to-back words with an ack between them
    ack_rx();
    u0 = n_under; o0 = n_over;
    write_tx(8'h81);
    spi_cs = 1'b0;
    k = 0;
    while (tx_full && k < 20) begin
      tick(1);
      k++;
    end
    check("t2_tx_full_fall", 16'(tx_full), 16'h0);
    write_tx(8'h7E);
    xfer(8'h12, 8, 1'b0, 1'b0, m1);
    check("t2_rx_data1", 16'(rx_data), 16'h12);
    check("t2_rx_valid1", 16'(rx_valid), 16'h1);
    ack_rx();
    check("t2_rx_valid_ack", 16'(rx_valid), 16'h0);
    xfer(8'h34, 8, 1'b1, 1'b0, m2);
    tick(6);
    check("t2_miso1", 16'(m1), 16'h81);
    check("t2_miso2", 16'(m2), 16'h7E);
    check("t2_rx_data2", 16'(rx_data), 16'h34);
    check("t2_overrun", 16'(n_over - o0), 16'h0);
    check("t2_underrun", 16'(n_under - u0), 16'h0);

    // Underrun and overrun: empty buffer, no ack
    ack_rx();
    tick(2);
    u0 = n_under; o0 = n_over;
    spi_cs = 1'b0;
    xfer(8'hC1, 8, 1'b0, 1'b0, m1);
    xfer(8'h5E, 8, 1'b1, 1'b0, m2);
    tick(6);
    check("t3_miso1", 16'(m1), 16'hFF);
    check("t3_miso2", 16'(m2), 16'hFF);
    check("t3_underrun", 16'(n_under - u0), 16'h2);
    check("t3_overrun", 16'(n_over - o0), 16'h1);
    check("t3_rx_data", 16'(rx_data), 16'h5E);

    // Abort after three bits
    ack_rx();
    tick(2);
    u0 = n_under; a0 = n_abort;
    spi_cs = 1'b0;
    xfer(8'hB0, 3, 1'b1, 1'b0, m1);
    k = 0;
    while (!spi_miso_oeb && k < 4) begin
      tick(1);
      k++;
    end
    check("t4_oeb_release", 16'(spi_miso_oeb), 16'h1);
    tick(4);
    check("t4_abort", 16'(n_abort - a0), 16'h1);
    check("t4_rx_valid", 16'(rx_valid), 16'h0);
    check("t4_rx_data_kept", 16'(rx_data), 16'h5E);
    check("t4_underrun", 16'(n_under - u0), 16'h1);
    write_tx(8'h5A);
    spi_cs = 1'b0;
    xfer(8'hC3, 8, 1'b1, 1'b0, m1);
    tick(6);
    check("t4_next_miso", 16'(m1), 16'h5A);
    check("t4_next_rx_data", 16'(rx_data), 16'hC3);
    check("t4_next_rx_valid", 16'(rx_valid), 16'h1);
    check("t4_abort_once", 16'(n_abort - a0), 16'h1);

    // Reset mid-frame
    a0 = n_abort;
    spi_cs = 1'b0;
    tick(5);
    write_tx(8'h99);
    xfer(8'hF0, 3, 1'b0, 1'b0, m1);
    rst = 1'b0;
    spi_cs = 1'b1;
    tick(1);
    rst = 1'b1;
    check("t5_miso", 16'(spi_miso), 16'h0);
    check("t5_oeb", 16'(spi_miso_oeb), 16'h1);
    check("t5_tx_full", 16'(tx_full), 16'h0);
    check("t5_rx_data", 16'(rx_data), 16'h00);
    check("t5_rx_valid", 16'(rx_valid), 16'h0);
    check("t5_busy", 16'(busy), 16'h0);
    tick(8);
    check("t5_no_abort", 16'(n_abort - a0), 16'h0);
    write_tx(8'h24);
    spi_cs = 1'b0;
    xfer(8'h6B, 8, 1'b1, 1'b0, m1);
    tick(6);
    check("t5_new_miso", 16'(m1), 16'h24);
    check("t5_new_rx_data", 16'(rx_data), 16'h6B);
    check("t5_new_rx_valid", 16'(rx_valid), 16'h1);

    // rx_ack on the completion cycle while rx_valid is already set
    o0 = n_over;
    write_tx(8'hE7);
    spi_cs = 1'b0;
    xfer(8'h9D, 8, 1'b1, 1'b1, m1);
    check("t6_rx_valid_now", 16'(rx_valid), 16'h1);
    tick(6);
    check("t6_rx_valid", 16'(rx_valid), 16'h1);
    check("t6_rx_data", 16'(rx_data), 16'h9D);
    check("t6_overrun", 16'(n_over - o0), 16'h0);
    check("t6_miso", 16'(m1), 16'hE7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
